// File: rtl/tx_preamble_gen.sv
// Frequency-domain 802.16 preamble source: emits one 256-bin symbol of QPSK pilots
// and zero bins into the TX IFFT stream under valid/ready flow control.
module tx_preamble_gen #(
    parameter int                      WIDTH    = 16,
    parameter logic signed [WIDTH-1:0] AMP      = 16'sd5793,
    parameter int                      LO_FIRST = 4,
    parameter int                      LO_LAST  = 100,
    parameter int                      HI_FIRST = 156,
    parameter int                      HI_LAST  = 252,
    parameter logic [255:0]            PN_SEQ   = {32{8'h1B}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    sym_sel_i,
    input  logic                    rdy_i,
    output logic signed [WIDTH-1:0] dat_re_o,
    output logic signed [WIDTH-1:0] dat_im_o,
    output logic                    stb_o,
    output logic [7:0]              bin_o,
    output logic                    sop_o,
    output logic                    eop_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic [6:0]              ptr_q, ptr_d;
    logic [7:0]              bin_d;
    logic signed [WIDTH-1:0] re_d, im_d;
    logic                    stb_d, sop_d, eop_d, busy_d, done_d;

    logic [7:0]              nbin;
    logic                    nsel;
    logic [6:0]              nptr;
    logic                    pilot;
    logic [1:0]              code;
    logic signed [WIDTH-1:0] nre, nim;
    logic                    load;

    // Spacing is a power of two, so the modulo test reduces to a mask.
    function automatic logic is_pilot(input logic [7:0] k, input logic sel);
        int kk;
        int msk;
        kk  = int'(k);
        msk = sel ? 1 : 3;
        if (kk >= LO_FIRST && kk <= LO_LAST) return ((kk - LO_FIRST) & msk) == 0;
        if (kk >= HI_FIRST && kk <= HI_LAST) return ((kk - HI_FIRST) & msk) == 0;
        return 1'b0;
    endfunction

    // The sample being prepared is bin 0 when starting, else the bin after the current one.
    always_comb begin
        nbin  = (state_q == IDLE) ? 8'd0 : bin_o + 8'd1;
        nsel  = (state_q == IDLE) ? sym_sel_i : sel_q;
        nptr  = (state_q == IDLE) ? 7'd0 : ptr_q;
        pilot = is_pilot(nbin, nsel);
        code  = PN_SEQ[{nptr, 1'b0} +: 2];
        nre   = '0;
        nim   = '0;
        if (pilot) begin
            nre = code[0] ? -AMP : AMP;
            nim = code[1] ? -AMP : AMP;
        end
    end

    // NOTE: every next-state signal gets a hold/default value first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        bin_d   = bin_o;
        re_d    = dat_re_o;
        im_d    = dat_im_o;
        stb_d   = stb_o;
        sop_d   = sop_o;
        eop_d   = eop_o;
        busy_d  = busy_o;
        done_d  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    sel_d   = sym_sel_i;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!stb_o || rdy_i) begin
                    if (stb_o && eop_o) begin
                        state_d = DONE;
                        stb_d   = 1'b0;
                        bin_d   = '0;
                        re_d    = '0;
                        im_d    = '0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            stb_d = 1'b1;
            bin_d = nbin;
            sop_d = (nbin == 8'd0);
            eop_d = (nbin == 8'hFF);
            re_d  = nre;
            im_d  = nim;
            ptr_d = pilot ? nptr + 7'd1 : nptr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            ptr_q    <= '0;
            bin_o    <= '0;
            dat_re_o <= '0;
            dat_im_o <= '0;
            stb_o    <= 1'b0;
            sop_o    <= 1'b0;
            eop_o    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            bin_o    <= bin_d;
            dat_re_o <= re_d;
            dat_im_o <= im_d;
            stb_o    <= stb_d;
            sop_o    <= sop_d;
            eop_o    <= eop_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end

endmodule

// File: tb/tb_tx_preamble_gen.sv
// Scoreboard bench for tx_preamble_gen: a reference model fills the expected 256-bin
// symbol when a start is driven; each accepted transfer pops and compares one entry.
module tb_tx_preamble_gen;

    typedef struct packed {
        logic [7:0]        bin;
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic              sop;
        logic              eop;
    } smp_t;

    logic clk = 1'b0;
    logic rst, start_i, sym_sel_i, rdy_i;

    logic signed [15:0] dat_re_o, dat_im_o;
    logic [7:0]         bin_o;
    logic               stb_o, sop_o, eop_o, busy_o, done_o;

    logic signed [15:0] a_re, a_im;
    logic [7:0]         a_bin;
    logic               a_stb, a_sop, a_eop, a_busy, a_done;

    smp_t q_main[$];
    smp_t q_alt[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tx_preamble_gen dut (
        .clk(clk), .rst(rst), .start_i(start_i), .sym_sel_i(sym_sel_i), .rdy_i(rdy_i),
        .dat_re_o(dat_re_o), .dat_im_o(dat_im_o), .stb_o(stb_o), .bin_o(bin_o),
        .sop_o(sop_o), .eop_o(eop_o), .busy_o(busy_o), .done_o(done_o)
    );

    tx_preamble_gen #(.AMP(16'sd100), .PN_SEQ('0)) dut_alt (
        .clk(clk), .rst(rst), .start_i(start_i), .sym_sel_i(sym_sel_i), .rdy_i(rdy_i),
        .dat_re_o(a_re), .dat_im_o(a_im), .stb_o(a_stb), .bin_o(a_bin),
        .sop_o(a_sop), .eop_o(a_eop), .busy_o(a_busy), .done_o(a_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic smp_t obs_main();
        return {bin_o, dat_re_o, dat_im_o, sop_o, eop_o};
    endfunction

    function automatic smp_t obs_alt();
        return {a_bin, a_re, a_im, a_sop, a_eop};
    endfunction

    // Reference model of one symbol, pushed as the start pulse is driven.
    task automatic push_sym(input logic sel, input bit alt);
        logic signed [15:0] amp;
        logic [255:0]       pn;
        logic [1:0]         code;
        int                 ptr, step;
        bit                 occ;
        smp_t               s;
        amp  = alt ? 16'sd100 : 16'sd5793;
        pn   = alt ? '0 : {32{8'h1B}};
        step = sel ? 2 : 4;
        ptr  = 0;
        for (int k = 0; k < 256; k++) begin
            occ = (k >= 4 && k <= 100 && (k - 4) % step == 0) ||
                  (k >= 156 && k <= 252 && (k - 156) % step == 0);
            s.bin = 8'(k);
            s.sop = (k == 0);
            s.eop = (k == 255);
            s.re  = '0;
            s.im  = '0;
            if (occ) begin
                code = pn[2*ptr +: 2];
                s.re = code[0] ? -amp : amp;
                s.im = code[1] ? -amp : amp;
                ptr  = (ptr + 1) % 128;
            end
            if (alt) q_alt.push_back(s);
            else     q_main.push_back(s);
        end
    endtask

    task automatic run_symbol(input logic sel, input bit rnd, input int stall_bin,
                              input int pulse_bin, input bit pulse_done,
                              input int abort_bin, input bit alt);
        smp_t            e;
        logic [42:0]     held;
        int              nz, nz_alt, stall_left;
        bit              stalled, finished;
        nz = 0; nz_alt = 0; stall_left = 3; stalled = 0; finished = 0;

        push_sym(sel, 1'b0);
        if (alt) push_sym(sel, 1'b1);
        start_i = 1'b1; sym_sel_i = sel; rdy_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; sym_sel_i = ~sel;
        check("first_stb", {stb_o, busy_o, bin_o, sop_o}, {1'b1, 1'b1, 8'd0, 1'b1});

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (stalled) check("hold", {stb_o, obs_main()}, held);
            if (abort_bin >= 0 && stb_o && int'(bin_o) == abort_bin) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_zero", {stb_o, busy_o, done_o, sop_o, eop_o, bin_o, dat_re_o, dat_im_o}, 64'd0);
                rst = 1'b0;
                q_main.delete();
                q_alt.delete();
                repeat (4) begin
                    @(negedge clk);
                    check("no_done_after_abort", {done_o, stb_o}, 64'd0);
                end
                return;
            end
            if (int'(bin_o) == stall_bin && stall_left > 0) begin
                rdy_i = 1'b0;
                stall_left--;
            end else if (rnd) rdy_i = ($urandom_range(0, 2) != 0);
            else rdy_i = 1'b1;
            start_i = (int'(bin_o) == pulse_bin);
            stalled = stb_o && !rdy_i;
            held    = {stb_o, obs_main()};
            if (stb_o && rdy_i) begin
                if (q_main.size() == 0) check("extra_sample", 64'(bin_o), 64'hFFFF);
                else begin
                    e = q_main.pop_front();
                    check("sample", obs_main(), e);
                end
                if (dat_re_o != 0 || dat_im_o != 0) nz++;
                if (sel == 1'b0 && bin_o == 8'd4) check("bin4", {dat_re_o, dat_im_o}, {-16'sd5793, -16'sd5793});
                if (sel == 1'b0 && bin_o == 8'd8) check("bin8", {dat_re_o, dat_im_o}, {16'sd5793, -16'sd5793});
                if (bin_o == 8'd5) check("bin5", {dat_re_o, dat_im_o}, 64'd0);
                if (sel == 1'b1 && bin_o == 8'd156) check("bin156", {dat_re_o, dat_im_o}, {16'sd5793, -16'sd5793});
                if (alt) begin
                    if (q_alt.size() == 0) check("alt_extra", 64'(a_bin), 64'hFFFF);
                    else begin
                        e = q_alt.pop_front();
                        check("alt_sample", {a_stb, obs_alt()}, {1'b1, e});
                    end
                    if (a_re != 0 || a_im != 0) nz_alt++;
                end
                if (eop_o) finished = 1'b1;
            end
            @(negedge clk);
        end

        start_i = 1'b0;
        rdy_i   = 1'b1;
        if (!finished) begin
            check("timeout", 64'd0, 64'd1);
            return;
        end
        start_i = pulse_done;
        check("done_pulse", {done_o, stb_o, busy_o}, 64'b100);
        @(negedge clk);
        start_i = 1'b0;
        check("idle_after_done", {done_o, stb_o, busy_o}, 64'd0);
        @(negedge clk);
        check("no_restart", {stb_o, busy_o}, 64'd0);
        check("queue_empty", 64'(q_main.size()), 64'd0);
        check("pilot_count", 64'(nz), sel ? 64'd98 : 64'd50);
        if (alt) check("alt_pilot_count", 64'(nz_alt), 64'd50);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; sym_sel_i = 1'b0; rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out", {stb_o, busy_o, done_o, sop_o, eop_o, bin_o, dat_re_o, dat_im_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // every 4th bin, full-rate ready
        run_symbol(1'b0, 1'b0, -1, -1, 1'b0, -1, 1'b0);
        // every 2nd bin
        run_symbol(1'b1, 1'b0, -1, -1, 1'b0, -1, 1'b0);
        // 3-cycle stall at bin 8 plus random backpressure
        run_symbol(1'b0, 1'b1, 8, -1, 1'b0, -1, 1'b0);
        // start re-pulsed mid-symbol and during done
        run_symbol(1'b0, 1'b0, -1, 50, 1'b1, -1, 1'b0);
        // reset mid-symbol, then a clean symbol from bin 0 / code 0
        run_symbol(1'b0, 1'b0, -1, -1, 1'b0, 120, 1'b0);
        @(negedge clk);
        run_symbol(1'b0, 1'b0, -1, -1, 1'b0, -1, 1'b0);
        // overridden instance: all-positive sign table, AMP = 100
        run_symbol(1'b0, 1'b0, -1, -1, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
